bit_reorder_stream: RTL and testbench

- Streaming, parametrised successor to the fixed 8-bit bit-reverse function.
- Accepts WIDTH-bit words over a valid/ready handshake and applies one of four run-time reorder modes: pass, full bit reverse, byte reverse, or bit reverse within each byte.
- Buffers results in a 2-entry output FIFO, so upstream and downstream can stall independently.
- Sits between a producer and consumer in the datapath test harness; also keeps a running count of completed output transfers.

---
 rtl/bit_reorder_pkg.sv | 19 +
 rtl/bit_reorder_xform.sv | 44 ++++
 rtl/bit_reorder_stream.sv | 99 +++++++++
 tb/tb_bit_reorder_stream.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bit_reorder_pkg.sv
// Shared types and elaboration helpers for the bit_reorder_stream block.
// Reorder mode encoding and width legality rule used by the datapath and FIFO.
package bit_reorder_pkg;

  typedef enum logic [1:0] {
    MODE_PASS           = 2'b00,
    MODE_BITREV         = 2'b01,
    MODE_BYTEREV        = 2'b10,
    MODE_BITREV_IN_BYTE = 2'b11
  } mode_e;

  localparam int BYTE_W     = 8;
  localparam int FIFO_DEPTH = 2;

  function automatic bit width_ok(input int w);
    return (w >= BYTE_W) && ((w % BYTE_W) == 0);
  endfunction

endpackage

// File: rtl/bit_reorder_xform.sv
// Combinational word reorder: pass, full bit reverse, byte reverse,
// or bit reverse inside each byte, selected by mode.
module bit_reorder_xform
  import bit_reorder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  mode_e            mode,
  output logic [WIDTH-1:0] result
);

  localparam int NBYTES = WIDTH / BYTE_W;

  logic [WIDTH-1:0] bitrev;
  logic [WIDTH-1:0] byterev;
  logic [WIDTH-1:0] inbyte;

  always_comb begin
    bitrev  = '0;
    byterev = '0;
    inbyte  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bitrev[WIDTH-1-i] = data[i];
    end
    for (int k = 0; k < NBYTES; k++) begin
      byterev[k*BYTE_W +: BYTE_W] = data[(NBYTES-1-k)*BYTE_W +: BYTE_W];
      for (int j = 0; j < BYTE_W; j++) begin
        inbyte[k*BYTE_W + BYTE_W-1-j] = data[k*BYTE_W + j];
      end
    end
  end

  always_comb begin
    case (mode)
      MODE_PASS:           result = data;
      MODE_BITREV:         result = bitrev;
      MODE_BYTEREV:        result = byterev;
      MODE_BITREV_IN_BYTE: result = inbyte;
      default:             result = data;
    endcase
  end

endmodule

// File: rtl/bit_reorder_stream.sv
// Streaming word reorder with a 2-entry output FIFO and a completed-transfer
// counter; in_ready depends only on registered occupancy.
module bit_reorder_stream
  import bit_reorder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] xfer_count
);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $fatal(1, "bit_reorder_stream: WIDTH must be a multiple of 8 and >= 8");
  end

  logic [WIDTH-1:0] xf_data;

  logic [WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [WIDTH-1:0] data_d [FIFO_DEPTH];
  mode_e            mode_q [FIFO_DEPTH];
  mode_e            mode_d [FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  bit_reorder_xform #(
    .WIDTH (WIDTH)
  ) u_xform (
    .data   (in_data),
    .mode   (mode_e'(in_mode)),
    .result (xf_data)
  );

  // A full FIFO refuses the push even when a pop happens on the same edge.
  assign in_ready  = (occ_q < 2'(FIFO_DEPTH));
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data   = data_q[rd_ptr_q];
  assign out_mode   = mode_q[rd_ptr_q];
  assign xfer_count = cnt_q;

  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    if (push) begin
      data_d[wr_ptr_q] = xf_data;
      mode_d[wr_ptr_q] = mode_e'(in_mode);
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      cnt_d    = cnt_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        data_q[e] <= '0;
        mode_q[e] <= MODE_PASS;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      cnt_q    <= '0;
    end else begin
      data_q   <= data_d;
      mode_q   <= mode_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bit_reorder_stream.sv
// Randomized and directed bench for bit_reorder_stream against a queue-based
// reference model of the FIFO and an arithmetic model of the reorder modes.
module tb_bit_reorder_stream;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_mode;
  logic [CNT_W-1:0] xfer_count;

  int total = 0;
  int bad   = 0;

  logic [33:0] q[$];
  int unsigned mcnt;

  bit_reorder_stream #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_mode   (out_mode),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    int r = 0;
    for (int i = 0; i < 8; i++) r = r * 2 + ((b >> i) & 1);
    return 8'(r);
  endfunction

  function automatic logic [31:0] ref_xf(input logic [31:0] d, input logic [1:0] m);
    logic [7:0]  by [4];
    logic [31:0] r = 0;
    for (int k = 0; k < 4; k++) by[k] = 8'(d >> (8 * k));
    for (int k = 0; k < 4; k++) begin
      case (m)
        2'd0: r = d;
        2'd1: r = r | (32'(rev8(by[k])) << (8 * (3 - k)));
        2'd2: r = r | (32'(by[k]) << (8 * (3 - k)));
        default: r = r | (32'(rev8(by[k])) << (8 * k));
      endcase
    end
    return r;
  endfunction

  // Called just after a falling edge: drive, check, step the model on the rising edge.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic [1:0] m, input logic ordy);
    bit exp_push, exp_pop;
    in_valid  = iv;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    #1;
    check_eq("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check_eq("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check_eq("out_data", out_data, q[0][31:0]);
      check_eq("out_mode", 32'(out_mode), 32'(q[0][33:32]));
    end
    check_eq("xfer_count", 32'(xfer_count), mcnt % 16);
    exp_push = iv && (q.size() < 2);
    exp_pop  = ordy && (q.size() > 0);
    @(posedge clk);
    if (exp_pop) begin
      void'(q.pop_front());
      mcnt++;
    end
    if (exp_push) q.push_back({m, ref_xf(d, m)});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_mode", 32'(out_mode), 32'd0);
    check_eq("rst_xfer_count", 32'(xfer_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    mcnt = 0;
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
    mcnt = 0;
    #1;
    do_reset();

    // Sustained streaming, counter wraps through 15 -> 0
    for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 2'($urandom), 1'b1);
    cycle(1'b0, 32'd0, 2'd0, 1'b1);
    check_eq("stream_wrap_cnt", 32'(xfer_count), 32'd4);

    cycle(1'b1, 32'h12345678, 2'b10, 1'b1);
    check_eq("byterev", out_data, 32'h78563412);
    cycle(1'b1, 32'h12345678, 2'b00, 1'b1);
    check_eq("pass", out_data, 32'h12345678);
    check_eq("pass_mode", 32'(out_mode), 32'd0);
    cycle(1'b1, 32'h00000F01, 2'b11, 1'b1);
    check_eq("bitrev_in_byte", out_data, 32'h0000F080);
    cycle(1'b1, 32'h00000F01, 2'b01, 1'b1);
    check_eq("bitrev", out_data, 32'h80F00000);
    cycle(1'b0, 32'd0, 2'd0, 1'b1);

    // Back-pressure: two fill, the third is refused until a pop
    cycle(1'b1, 32'd1, 2'b01, 1'b0);
    cycle(1'b1, 32'd2, 2'b01, 1'b0);
    check_eq("bp_full_in_ready", 32'(in_ready), 32'd0);
    check_eq("bp_head", out_data, 32'h80000000);
    cycle(1'b1, 32'd3, 2'b01, 1'b0);
    check_eq("bp_hold", out_data, 32'h80000000);
    cycle(1'b1, 32'd3, 2'b01, 1'b1);
    check_eq("bp_second", out_data, 32'h40000000);
    cycle(1'b1, 32'd3, 2'b01, 1'b1);
    check_eq("bp_third", out_data, 32'hC0000000);
    cycle(1'b0, 32'd0, 2'd0, 1'b1);

    // Reset with two words buffered
    cycle(1'b1, $urandom, 2'($urandom), 1'b0);
    cycle(1'b1, $urandom, 2'($urandom), 1'b0);
    do_reset();
    cycle(1'b1, 32'h01020304, 2'b11, 1'b1);
    check_eq("post_rst_word", out_data, 32'h8040C020);
    check_eq("post_rst_valid", 32'(out_valid), 32'd1);
    cycle(1'b0, 32'd0, 2'd0, 1'b1);

    for (int i = 0; i < 400; i++)
      cycle(($urandom % 4) != 0, $urandom, 2'($urandom), ($urandom % 3) != 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
